led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter NB_LEDS, default 4: width of the controlled LED shift register; rotation length in steps.
REQ-002 Parameter NB_COUNT, default 32: prescaler counter width.
REQ-003 Parameters LIMIT0..LIMIT3, defaults 2**23, 2**24, 2**25, 2**26: prescaler periods in clock cycles, each >= 2.
REQ-004 Parameter FLASH_TICKS, default 8: prescaler ticks spent in FLASH.
REQ-005 clock  in  1  sole clock; all state on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_sw  in  4  [0] run enable, [2:1] speed select (LIMIT0..LIMIT3), [3] direction (0 left, 1 right).
REQ-008 i_btn  in  1  flash request, level input; rising edge is the event.
REQ-009 o_load  out  1  one-cycle strobe: shift register loads seed 1 at bit 0.
REQ-010 o_step  out  1  one-cycle strobe: shift register rotates one position.
REQ-011 o_dir  out  1  rotation direction, valid with o_step.
REQ-012 o_blank  out  1  1 forces LEDs off.
REQ-013 o_wrap  out  1  one-cycle strobe on completion of a full rotation.
REQ-014 o_state  out  2  FSM state: 0 IDLE, 1 RUN, 2 HOLD, 3 FLASH.

Function
REQ-015 The FSM SHALL use states IDLE, RUN, HOLD, FLASH; LOAD is a 1-cycle pulse issued on entry to RUN from IDLE or FLASH, not a state.
REQ-016 IDLE -> RUN when run enable = 1; o_load = 1 in the first RUN cycle; prescaler and step counter cleared.
REQ-017 RUN: prescaler increments every cycle; at count == LIMITsel-1, o_step = 1 for that cycle and prescaler wraps to 0.
REQ-018 Step latency: first o_step exactly LIMITsel cycles after o_load.
REQ-019 o_dir SHALL update from i_sw[3] only in cycles with o_step = 1; direction changes between steps take effect at the next step.
REQ-020 Speed change: if prescaler >= new LIMIT-1, prescaler clears to 0 with no o_step that cycle; otherwise counting continues.
REQ-021 Step counter counts o_step modulo NB_LEDS; o_wrap = 1 in the same cycle as the step that returns it to 0.
REQ-022 RUN -> HOLD when run enable = 0; HOLD freezes prescaler and step counter; o_step, o_load = 0.
REQ-023 HOLD -> RUN when run enable = 1; counting resumes from frozen values, no o_load.
REQ-024 RUN or HOLD -> FLASH on i_btn rising edge, provided run enable = 1; if run enable = 0 in the same cycle, RUN -> HOLD wins and the edge is dropped.
REQ-025 FLASH: prescaler runs at LIMITsel; o_blank toggles on each tick (first toggle sets 1); o_step = 0.
REQ-026 FLASH exits after FLASH_TICKS ticks with o_blank = 0, to RUN with o_load, or to IDLE if run enable = 0 at that cycle.
REQ-027 Button edges during FLASH SHALL be ignored.
REQ-028 Run enable = 0 in IDLE: remain in IDLE; all strobes 0.
REQ-029 At most one of o_load, o_step asserted in any cycle.

Reset
REQ-030 i_reset low SHALL immediately force state IDLE, prescaler 0, step counter 0, edge-detect history 0, and all outputs 0, regardless of clock.
REQ-031 Reset mid-operation discards all progress; release returns to REQ-016 behaviour with no spurious strobe in the release cycle.

Configuration
REQ-032 Macro SYNC_INPUTS_EN defined: i_sw and i_btn pass through 2-flop synchronisers, adding 2 cycles to every input-to-response latency.
REQ-033 Macro SYNC_INPUTS_EN undefined: inputs sampled directly; IDLE -> RUN on the first edge seeing run enable = 1.

Verification (LIMIT0..3 = 4, 6, 8, 10; FLASH_TICKS = 4; NB_LEDS = 4; SYNC_INPUTS_EN undefined)
REQ-034 Reset, i_sw = 4'b0001 -> o_load at cycle 1, o_step every 4 cycles, o_wrap on 4th step, o_dir = 0.
REQ-035 RUN, drop i_sw[0] for 10 cycles at prescaler 2 -> no strobes; after re-enable, o_step exactly 2 cycles later, no o_load.
REQ-036 RUN at speed 3, prescaler 7, switch to speed 0 -> prescaler clears, no step; next o_step 4 cycles later.
REQ-037 i_btn rise in RUN at speed 0 -> o_state = 3, o_blank toggles every 4 cycles for 16 cycles, then o_load, RUN.
REQ-038 Assert i_reset low mid-FLASH between clock edges -> outputs 0 and o_state = 0 immediately; restart per REQ-034.
REQ-039 Toggle i_sw[3] 1 cycle after a step -> o_dir unchanged until next o_step, then 1.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// led_seq_ctrl
//   Sequencer for a rotating LED shift register. A prescaler divides the
//   clock down to a selectable step rate; each step strobe rotates the
//   external shift register one position. A button press flashes the LEDs
//   for FLASH_TICKS prescaler ticks, after which the pattern is reseeded.
//
// Configuration macro:
//   SYNC_INPUTS_EN - when defined, i_sw and i_btn pass through 2-flop
//                    synchronisers (two extra cycles of input latency).
//
// Ports:
//   clock      in   sole clock, rising edge
//   i_reset    in   asynchronous active-low reset
//   i_sw[3:0]  in   [0] run enable, [2:1] speed select, [3] direction
//   i_btn      in   flash request (level; rising edge is the event)
//   o_load     out  1-cycle strobe: load seed 1 at bit 0
//   o_step     out  1-cycle strobe: rotate one position
//   o_dir      out  rotation direction (0 left, 1 right), valid with o_step
//   o_blank    out  1 forces LEDs off
//   o_wrap     out  1-cycle strobe on completion of a full rotation
//   o_state    out  FSM state: 0 IDLE, 1 RUN, 2 HOLD, 3 FLASH
// ---------------------------------------------------------------------------
module led_seq_ctrl #(
    parameter int NB_LEDS     = 4,
    parameter int NB_COUNT    = 32,
    parameter int LIMIT0      = 2**23,
    parameter int LIMIT1      = 2**24,
    parameter int LIMIT2      = 2**25,
    parameter int LIMIT3      = 2**26,
    parameter int FLASH_TICKS = 8
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [3:0] i_sw,
    input  logic       i_btn,
    output logic       o_load,
    output logic       o_step,
    output logic       o_dir,
    output logic       o_blank,
    output logic       o_wrap,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLASH = 2'd3
    } state_t;

    localparam int CNT_W = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
    localparam int FT_W  = $clog2(FLASH_TICKS + 1);

    localparam logic [NB_COUNT-1:0] LIM0_M1 = NB_COUNT'(LIMIT0 - 1);
    localparam logic [NB_COUNT-1:0] LIM1_M1 = NB_COUNT'(LIMIT1 - 1);
    localparam logic [NB_COUNT-1:0] LIM2_M1 = NB_COUNT'(LIMIT2 - 1);
    localparam logic [NB_COUNT-1:0] LIM3_M1 = NB_COUNT'(LIMIT3 - 1);

    logic [3:0] w_sw;
    logic       w_btn;

`ifdef SYNC_INPUTS_EN
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_btn, i_sw};
            r_sync2 <= r_sync1;
        end
    end

    assign w_sw  = r_sync2[3:0];
    assign w_btn = r_sync2[4];
`else
    assign w_sw  = i_sw;
    assign w_btn = i_btn;
`endif

    state_t              r_state, w_state_nxt;
    logic [NB_COUNT-1:0] r_pre, w_pre_nxt, w_pre_adv;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [FT_W-1:0]     r_ft, w_ft_nxt;
    logic [1:0]          r_sel;
    logic                r_btn_q;
    logic                r_load, r_step, r_dir, r_blank, r_wrap;
    logic                w_load_nxt, w_step_nxt, w_dir_nxt, w_blank_nxt, w_wrap_nxt;
    logic [NB_COUNT-1:0] w_lim_m1;
    logic                w_tick;
    logic                w_run;
    logic                w_rise;
    logic                w_sel_chg;

    assign w_run     = w_sw[0];
    assign w_rise    = w_btn & ~r_btn_q;
    assign w_sel_chg = (w_sw[2:1] != r_sel);

    always_comb begin
        case (w_sw[2:1])
            2'd0:    w_lim_m1 = LIM0_M1;
            2'd1:    w_lim_m1 = LIM1_M1;
            2'd2:    w_lim_m1 = LIM2_M1;
            default: w_lim_m1 = LIM3_M1;
        endcase
    end

    // Prescaler advance. A speed change that leaves the count at or past the
    // new terminal value restarts the period without a tick. A count beyond
    // the terminal value (speed changed while frozen) also restarts silently
    // so the counter can never run away past the limit.
    always_comb begin
        w_tick    = 1'b0;
        w_pre_adv = r_pre + 1'b1;
        if ((r_pre > w_lim_m1) || (w_sel_chg && (r_pre >= w_lim_m1))) begin
            w_pre_adv = '0;
        end else if (r_pre == w_lim_m1) begin
            w_tick    = 1'b1;
            w_pre_adv = '0;
        end
    end

    // Next-state and registered-output logic. Strobes are computed here and
    // registered, so each one appears in the cycle after the deciding edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_cnt_nxt   = r_cnt;
        w_ft_nxt    = r_ft;
        w_blank_nxt = r_blank;
        w_dir_nxt   = r_dir;
        w_load_nxt  = 1'b0;
        w_step_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_run) begin
                    w_state_nxt = ST_RUN;
                    w_load_nxt  = 1'b1;
                    w_pre_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_blank_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                // Disable has priority: a coincident button edge is dropped.
                if (!w_run) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_rise) begin
                    w_state_nxt = ST_FLASH;
                    w_pre_nxt   = '0;
                    w_ft_nxt    = '0;
                    w_blank_nxt = 1'b0;
                end else begin
                    w_pre_nxt = w_pre_adv;
                    if (w_tick) begin
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = w_sw[3];
                        if (r_cnt == CNT_W'(NB_LEDS - 1)) begin
                            w_cnt_nxt  = '0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_run) begin
                    if (w_rise) begin
                        w_state_nxt = ST_FLASH;
                        w_pre_nxt   = '0;
                        w_ft_nxt    = '0;
                        w_blank_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: begin  // ST_FLASH
                w_pre_nxt = w_pre_adv;
                if (w_tick) begin
                    if (r_ft == FT_W'(FLASH_TICKS - 1)) begin
                        w_ft_nxt    = '0;
                        w_blank_nxt = 1'b0;
                        w_pre_nxt   = '0;
                        if (w_run) begin
                            w_state_nxt = ST_RUN;
                            w_load_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_ft_nxt    = r_ft + 1'b1;
                        w_blank_nxt = ~r_blank;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_ft    <= '0;
            r_sel   <= '0;
            r_btn_q <= 1'b0;
            r_load  <= 1'b0;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_blank <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ft    <= w_ft_nxt;
            r_sel   <= w_sw[2:1];
            r_btn_q <= w_btn;
            r_load  <= w_load_nxt;
            r_step  <= w_step_nxt;
            r_dir   <= w_dir_nxt;
            r_blank <= w_blank_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign o_load  = r_load;
    assign o_step  = r_step;
    assign o_dir   = r_dir;
    assign o_blank = r_blank;
    assign o_wrap  = r_wrap;
    assign o_state = r_state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_seq_ctrl
//   Directed bench for led_seq_ctrl with LIMIT0..3 = 4, 6, 8, 10,
//   FLASH_TICKS = 4, NB_LEDS = 4. Cycle numbers in comments count rising
//   edges since the run enable was first seen (edge 1 produces o_load).
//   Outputs are compared 1 time unit after each rising edge as a packed
//   vector {state[1:0], load, step, wrap, dir, blank}.
// ---------------------------------------------------------------------------
module tb_led_seq_ctrl;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FLASH = 2'd3;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [3:0] i_sw;
    logic       i_btn;
    logic       o_load, o_step, o_dir, o_blank, o_wrap;
    logic [1:0] o_state;
    logic [6:0] outs;

    int n_pass  = 0;
    int n_total = 0;

    led_seq_ctrl #(
        .NB_LEDS(4), .NB_COUNT(32),
        .LIMIT0(4), .LIMIT1(6), .LIMIT2(8), .LIMIT3(10),
        .FLASH_TICKS(4)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_sw(i_sw), .i_btn(i_btn),
        .o_load(o_load), .o_step(o_step), .o_dir(o_dir), .o_blank(o_blank),
        .o_wrap(o_wrap), .o_state(o_state)
    );

    assign outs = {o_state, o_load, o_step, o_wrap, o_dir, o_blank};

    // clock / reset block
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] pack(input logic [1:0] st, input logic ld,
                                        input logic stp, input logic wrp,
                                        input logic dir, input logic blk);
        return {st, ld, stp, wrp, dir, blk};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {st,ld,stp,wrp,dir,blk}=%b expected %b", tag, obs, exp);
    endtask

    initial begin
        logic blk;
        i_reset = 1'b0;
        i_sw    = 4'b0000;
        i_btn   = 1'b0;

        // Reset state and IDLE with run disabled
        repeat (3) cyc();
        chk("reset_outs", outs, 7'b0);
        #2 i_reset = 1'b1;
        repeat (3) cyc();
        chk("idle_no_run", outs, 7'b0);

        // Start: load at cycle 1, steps every 4 cycles, wrap on 4th step
        i_sw = 4'b0001;
        cyc();  // 1
        chk("a_load", outs, pack(S_RUN, 1, 0, 0, 0, 0));
        for (int c = 2; c <= 17; c++) begin
            cyc();
            chk("a_run", outs, pack(S_RUN, 0, ((c - 1) % 4 == 0), (c == 17), 0, 0));
        end

        // Hold at prescaler 2 for 10 cycles, resume: step 2 cycles later
        cyc(); cyc();  // 19, prescaler 2
        chk("b_pre", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        i_sw = 4'b0000;
        for (int c = 20; c <= 29; c++) begin
            cyc();
            chk("b_hold", outs, pack(S_HOLD, 0, 0, 0, 0, 0));
        end
        i_sw = 4'b0001;
        cyc();  // 30
        chk("b_resume", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        cyc();  // 31
        chk("b_resume2", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        cyc();  // 32
        chk("b_step", outs, pack(S_RUN, 0, 1, 0, 0, 0));

        // Direction toggled one cycle after a step takes effect at next step
        cyc();  // 33
        chk("c_after_step", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        i_sw = 4'b1001;
        cyc(); cyc();  // 35
        chk("c_dir_wait", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        cyc();  // 36
        chk("c_dir_step", outs, pack(S_RUN, 0, 1, 0, 1, 0));

        // Speed 3, then at prescaler 7 switch to speed 0: clear, no step
        i_sw = 4'b1111;
        for (int c = 37; c <= 43; c++) begin
            cyc();
            chk("d_slow", outs, pack(S_RUN, 0, 0, 0, 1, 0));
        end
        i_sw = 4'b1001;
        for (int c = 44; c <= 47; c++) begin
            cyc();
            chk("d_clear", outs, pack(S_RUN, 0, 0, 0, 1, 0));
        end
        cyc();  // 48
        chk("d_step", outs, pack(S_RUN, 0, 1, 0, 1, 0));
        repeat (3) cyc();
        cyc();  // 52
        chk("d_wrap", outs, pack(S_RUN, 0, 1, 1, 1, 0));

        // Flash: blank toggles every 4 cycles for 16 cycles, then reload
        i_btn = 1'b1;
        for (int c = 53; c <= 68; c++) begin
            cyc();
            blk = ((c >= 57) && (c <= 60)) || ((c >= 65) && (c <= 68));
            chk("e_flash", outs, pack(S_FLASH, 0, 0, 0, 1, blk));
            if (c == 55) i_btn = 1'b0;
            if (c == 58) i_btn = 1'b1;  // edge inside FLASH must be ignored
        end
        cyc();  // 69
        chk("e_exit_load", outs, pack(S_RUN, 1, 0, 0, 1, 0));
        repeat (3) cyc();
        cyc();  // 73
        chk("e_step", outs, pack(S_RUN, 0, 1, 0, 1, 0));

        // Asynchronous reset mid-FLASH
        i_btn = 1'b0;
        cyc();  // 74
        i_btn = 1'b1;
        cyc();  // 75
        chk("f_flash", outs, pack(S_FLASH, 0, 0, 0, 1, 0));
        repeat (4) cyc();  // 79
        chk("f_blank", outs, pack(S_FLASH, 0, 0, 0, 1, 1));
        #2 i_reset = 1'b0;
        #1;
        chk("f_async", outs, 7'b0);
        i_btn = 1'b0;
        i_sw  = 4'b0001;
        repeat (2) cyc();
        chk("f_in_reset", outs, 7'b0);
        #2 i_reset = 1'b1;
        #1;
        chk("f_release", outs, 7'b0);
        cyc();  // 1
        chk("f_load", outs, pack(S_RUN, 1, 0, 0, 0, 0));
        repeat (3) cyc();
        chk("f_no_step", outs, pack(S_RUN, 0, 0, 0, 0, 0));
        cyc();  // 5
        chk("f_step", outs, pack(S_RUN, 0, 1, 0, 0, 0));

        // Disable and button edge together: HOLD wins, edge dropped
        i_sw  = 4'b0000;
        i_btn = 1'b1;
        cyc();
        chk("g_tie_hold", outs, pack(S_HOLD, 0, 0, 0, 0, 0));
        i_sw = 4'b0001;
        cyc();
        chk("g_resume_run", outs, pack(S_RUN, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
